rom_sync_responder: RTL and testbench
=====================================

# rom_sync_responder

ROM-side bus responder for the 4-bit instruction bus. It tracks the CPU's 8-cycle instruction microcycle from the CPU-driven `sync` strobe, captures the three address nibbles, and drives the two opcode nibbles back onto the bus when its chip ID matches. It is a program-ROM device: 256 x 8 storage, loaded through a side write port, sitting on the shared data bus opposite the CPU's microcycle sequencer.

## Interface
- `CHIP_ID`, default 4'h0: value of the A3 nibble that selects this ROM.
- `clk`  input  1  rising-edge clock, one bus cycle per clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `sync`  input  1  CPU strobe, high during X3 (cycle 7); the following cycle is A1.
- `d_in`  input  4  bus value driven by the CPU.
- `d_out`  output  4  opcode nibble driven by this ROM.
- `d_oe`  output  1  bus drive enable for `d_out`.
- `prog_we`  input  1  ROM write strobe.
- `prog_addr`  input  8  ROM write address.
- `prog_data`  input  8  ROM write data, {OPR, OPA}.
- `phase`  output  3  current cycle label: 0=A1, 1=A2, 2=A3, 3=M1, 4=M2, 5=X1, 6=X2, 7=X3.
- `locked`  output  1  phase tracking valid.
- `hit`  output  1  one-cycle pulse: this ROM is selected for the current instruction.
- `sync_err`  output  1  one-cycle pulse: `sync` protocol violation.

## Operation
- Reset (async, `rst_n`=0): `phase`=0, `locked`=0, `d_out`=0, `d_oe`=0, `hit`=0, `sync_err`=0, address latches=0. ROM contents are not reset.
- Phase tracking, evaluated at every rising edge:
  - `sync`=1 while unlocked: `phase`<=0, `locked`<=1.
  - `sync`=1 while locked and `phase`==7: normal; `phase`<=0.
  - `sync`=1 while locked and `phase`!=7: `sync_err` pulse, `phase`<=0, `locked` stays 1, any in-progress drive is aborted (`d_oe`<=0).
  - `sync`=0 while locked and `phase`==7: missing strobe; `sync_err` pulse, `locked`<=0, `phase`<=0.
  - `sync`=0 otherwise: locked: `phase`<=`phase`+1; unlocked: `phase` holds 0.
- Address capture (locked only): at the edge ending A1, latch `d_in` as addr[3:0]. At the edge ending A2, latch `d_in` as addr[7:4].
- Selection: at the edge ending A3, selected = (`d_in`==`CHIP_ID`). If selected: `d_out`<=mem[addr][7:4], `d_oe`<=1, `hit`<=1 for one cycle, and latch mem[addr][3:0] internally. If not selected: `d_oe` stays 0.
- At the edge ending M1, if driving: `d_out`<=latched low nibble, `d_oe` stays 1.
- At the edge ending M2: `d_oe`<=0, `d_out`<=0.
- `d_oe` is never 1 outside M1/M2 and never 1 while unlocked.
- Program port: `prog_we`=1 writes `prog_data` to mem[`prog_addr`] at the edge. This is independent of bus state.
- Write/read collision: if the write and the A3 read hit the same address at the same edge, the read returns the old data.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: the OPR nibble is valid for the whole of cycle M1 (one clock after the A3 sample). The OPA nibble is valid for the whole of M2.
- `hit` is high exactly during M1.
- `sync_err` is high for the one cycle after the offending edge.
- First instruction after reset or lock loss: `sync` must be seen first. The A1 sample occurs at the edge one clock after the `sync` edge.
- Reset asserted mid-drive: `d_oe` falls asynchronously, with no wait for a clock.
- Wrap-around: `phase` advances 7→0 only together with `sync`. Address 8'hFF is legal, with no wrap logic.

## Test plan
- Lock-up and fetch: load mem[8'h3C]=8'hA5 with `CHIP_ID`=2. Pulse `sync`, then bus nibbles C, 3, 2 -> `hit`=1 in M1, `d_out`=A with `d_oe`=1 in M1, `d_out`=5 with `d_oe`=1 in M2, `d_oe`=0 in X1–X3.
- Chip mismatch: same fetch with A3=7 -> `d_oe` stays 0 and `hit` stays 0 for the entire cycle. `phase` still sequences 0..7.
- Back-to-back: four consecutive instructions at addresses 00, 01, FF, 80 -> each returns the correct mem byte, `sync_err` stays 0, and `locked` stays 1.
- Early `sync` at M1 while driving -> `sync_err` pulse, `d_oe`=0 in the next cycle, `phase`=0. The next A1..A3 fetch completes correctly.
- Missing `sync` at X3 -> `sync_err` pulse, `locked`=0, and no drive. The following `sync` relocks and the fetch succeeds.
- Reset during M1 with `d_oe`=1 -> `d_oe`=0 immediately and all outputs hold reset values. Also: a same-edge program write to 8'h3C with data 8'h11 during A3 returns the old A5.

Source files
------------

// File: rtl/rom_sync_responder.sv
// Program-ROM responder for the 4-bit instruction bus: follows the CPU microcycle
// from sync, captures A1..A3, and returns the stored opcode byte during M1/M2.
module rom_sync_responder #(
    parameter logic [3:0] CHIP_ID = 4'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sync,
    input  logic [3:0] d_in,
    output logic [3:0] d_out,
    output logic       d_oe,
    input  logic       prog_we,
    input  logic [7:0] prog_addr,
    input  logic [7:0] prog_data,
    output logic [2:0] phase,
    output logic       locked,
    output logic       hit,
    output logic       sync_err
);

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_t;

    logic [7:0] mem_r [256];
    logic [7:0] mem_rd_s;

    phase_t     phase_r, phase_s;
    logic       locked_r, locked_s;
    logic [7:0] addr_r, addr_s;
    logic [3:0] opa_r, opa_s;
    logic [3:0] d_out_r, d_out_s;
    logic       d_oe_r, d_oe_s;
    logic       hit_r, hit_s;
    logic       sync_err_r, sync_err_s;

    // Program port: storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem_r[prog_addr] <= prog_data;
        end
    end

    // Read returns pre-write contents when a write lands on the same edge.
    always_comb begin
        mem_rd_s = mem_r[addr_r];
    end

    // Next-state: phase tracking, address capture and opcode drive sequencing.
    always_comb begin
        phase_s    = phase_r;
        locked_s   = locked_r;
        addr_s     = addr_r;
        opa_s      = opa_r;
        d_out_s    = d_out_r;
        d_oe_s     = d_oe_r;
        hit_s      = 1'b0;
        sync_err_s = 1'b0;

        if (sync) begin
            phase_s  = PH_A1;
            locked_s = 1'b1;
            if (locked_r && (phase_r != PH_X3)) begin
                // Early strobe: resynchronise and drop any drive in progress.
                sync_err_s = 1'b1;
                d_oe_s     = 1'b0;
                d_out_s    = 4'h0;
            end else begin
                sync_err_s = 1'b0;
            end
        end else if (locked_r) begin
            if (phase_r == PH_X3) begin
                sync_err_s = 1'b1;
                locked_s   = 1'b0;
                phase_s    = PH_A1;
                d_oe_s     = 1'b0;
                d_out_s    = 4'h0;
            end else begin
                phase_s = phase_t'(phase_r + 3'd1);
                case (phase_r)
                    PH_A1: addr_s[3:0] = d_in;
                    PH_A2: addr_s[7:4] = d_in;
                    PH_A3: begin
                        if (d_in == CHIP_ID) begin
                            d_out_s = mem_rd_s[7:4];
                            opa_s   = mem_rd_s[3:0];
                            d_oe_s  = 1'b1;
                            hit_s   = 1'b1;
                        end else begin
                            d_oe_s  = 1'b0;
                        end
                    end
                    PH_M1: begin
                        if (d_oe_r) begin
                            d_out_s = opa_r;
                        end else begin
                            d_out_s = d_out_r;
                        end
                    end
                    PH_M2: begin
                        d_oe_s  = 1'b0;
                        d_out_s = 4'h0;
                    end
                    default: begin
                        d_oe_s = 1'b0;
                    end
                endcase
            end
        end else begin
            phase_s = PH_A1;
        end
    end

    // State and output registers; reset clears the bus drive without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r    <= PH_A1;
            locked_r   <= 1'b0;
            addr_r     <= 8'h00;
            opa_r      <= 4'h0;
            d_out_r    <= 4'h0;
            d_oe_r     <= 1'b0;
            hit_r      <= 1'b0;
            sync_err_r <= 1'b0;
        end else begin
            phase_r    <= phase_s;
            locked_r   <= locked_s;
            addr_r     <= addr_s;
            opa_r      <= opa_s;
            d_out_r    <= d_out_s;
            d_oe_r     <= d_oe_s;
            hit_r      <= hit_s;
            sync_err_r <= sync_err_s;
        end
    end

    assign phase    = phase_r;
    assign locked   = locked_r;
    assign d_out    = d_out_r;
    assign d_oe     = d_oe_r;
    assign hit      = hit_r;
    assign sync_err = sync_err_r;

endmodule

// File: tb/tb_rom_sync_responder.sv
// Self-checking bench for rom_sync_responder: instruction-level reference model
// with a mirrored ROM image, directed protocol cases and randomized fetches.
module tb_rom_sync_responder;

    localparam logic [3:0] CHIP = 4'h2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sync;
    logic [3:0] d_in;
    logic [3:0] d_out;
    logic       d_oe;
    logic       prog_we;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;
    logic [2:0] phase;
    logic       locked;
    logic       hit;
    logic       sync_err;

    logic [7:0] ref_mem [256];
    logic [7:0] cur_addr;
    logic       rand_prog;
    int         checks;
    int         failures;

    rom_sync_responder #(.CHIP_ID(CHIP)) dut (
        .clk(clk), .rst_n(rst_n), .sync(sync), .d_in(d_in),
        .d_out(d_out), .d_oe(d_oe), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .phase(phase), .locked(locked), .hit(hit),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: the ROM image follows the program port, then inputs return to idle.
    task automatic step();
        @(posedge clk);
        if (prog_we) ref_mem[prog_addr] = prog_data;
        #1;
        prog_we = 1'b0;
        sync    = 1'b0;
    endtask

    task automatic rand_wr();
        if (rand_prog && ($urandom_range(0, 3) == 0)) begin
            prog_we   = 1'b1;
            prog_addr = ($urandom_range(0, 1) == 1) ? cur_addr : 8'($urandom);
            prog_data = 8'($urandom);
        end
    endtask

    task automatic check_idle_bus(input string tag, input logic [2:0] exp_phase);
        check_eq({tag, "_phase"}, 8'(phase), 8'(exp_phase));
        check_eq({tag, "_locked"}, 8'(locked), 8'd1);
        check_eq({tag, "_oe"}, 8'(d_oe), 8'd0);
        check_eq({tag, "_hit"}, 8'(hit), 8'd0);
        check_eq({tag, "_err"}, 8'(sync_err), 8'd0);
    endtask

    task automatic sync_step();
        sync = 1'b1;
        d_in = 4'($urandom);
        rand_wr();
        step();
        check_idle_bus("sync", 3'd0);
    endtask

    // Starts in A1 (sync already taken); ends in X3.
    task automatic fetch_body(input logic [7:0] a, input logic [3:0] a3,
                              input logic do_wr, input logic [7:0] wr_data);
        logic [7:0] exp;
        logic       sel;
        cur_addr = a;
        d_in = a[3:0]; rand_wr(); step();
        check_idle_bus("a2", 3'd1);
        d_in = a[7:4]; rand_wr(); step();
        check_idle_bus("a3", 3'd2);
        exp = ref_mem[a];
        sel = (a3 == CHIP);
        d_in = a3;
        if (do_wr) begin
            prog_we = 1'b1; prog_addr = a; prog_data = wr_data;
        end else begin
            rand_wr();
        end
        step();
        check_eq("m1_phase", 8'(phase), 8'd3);
        check_eq("m1_hit", 8'(hit), 8'(sel));
        check_eq("m1_oe", 8'(d_oe), 8'(sel));
        check_eq("m1_err", 8'(sync_err), 8'd0);
        if (sel) check_eq("m1_opr", 8'(d_out), 8'(exp[7:4]));
        d_in = 4'($urandom); rand_wr(); step();
        check_eq("m2_phase", 8'(phase), 8'd4);
        check_eq("m2_hit", 8'(hit), 8'd0);
        check_eq("m2_oe", 8'(d_oe), 8'(sel));
        if (sel) check_eq("m2_opa", 8'(d_out), 8'(exp[3:0]));
        for (int p = 5; p <= 7; p++) begin
            d_in = 4'($urandom); rand_wr(); step();
            check_idle_bus("x", 3'(p));
        end
    endtask

    task automatic fetch(input logic [7:0] a, input logic [3:0] a3,
                         input logic do_wr, input logic [7:0] wr_data);
        sync_step();
        fetch_body(a, a3, do_wr, wr_data);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_phase"}, 8'(phase), 8'd0);
        check_eq({tag, "_locked"}, 8'(locked), 8'd0);
        check_eq({tag, "_dout"}, 8'(d_out), 8'd0);
        check_eq({tag, "_oe"}, 8'(d_oe), 8'd0);
        check_eq({tag, "_hit"}, 8'(hit), 8'd0);
        check_eq({tag, "_err"}, 8'(sync_err), 8'd0);
    endtask

    initial begin
        logic [7:0] b2b [4];
        logic [7:0] ra;
        logic [3:0] ra3;
        checks = 0; failures = 0; rand_prog = 1'b0; cur_addr = 8'h00;
        rst_n = 1'b0; sync = 1'b0; d_in = 4'h0;
        prog_we = 1'b0; prog_addr = 8'h00; prog_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Load the whole ROM while the bus is idle (unlocked).
        for (int i = 0; i < 256; i++) begin
            prog_we = 1'b1; prog_addr = 8'(i); prog_data = 8'($urandom);
            step();
        end
        prog_we = 1'b1; prog_addr = 8'h3C; prog_data = 8'hA5;
        step();
        check_reset_outputs("idle");

        fetch(8'h3C, CHIP, 1'b0, 8'h00);
        fetch(8'h3C, 4'h7, 1'b0, 8'h00);

        b2b[0] = 8'h00; b2b[1] = 8'h01; b2b[2] = 8'hFF; b2b[3] = 8'h80;
        for (int i = 0; i < 4; i++) fetch(b2b[i], CHIP, 1'b0, 8'h00);

        // Early sync while M1 is being driven.
        sync_step();
        d_in = 4'hC; step();
        d_in = 4'h3; step();
        d_in = CHIP; step();
        check_eq("early_pre_oe", 8'(d_oe), 8'd1);
        sync = 1'b1; step();
        check_eq("early_err", 8'(sync_err), 8'd1);
        check_eq("early_oe", 8'(d_oe), 8'd0);
        check_eq("early_phase", 8'(phase), 8'd0);
        check_eq("early_locked", 8'(locked), 8'd1);
        fetch_body(8'h5A, CHIP, 1'b0, 8'h00);

        // Missing sync at X3.
        step();
        check_eq("miss_err", 8'(sync_err), 8'd1);
        check_eq("miss_locked", 8'(locked), 8'd0);
        check_eq("miss_phase", 8'(phase), 8'd0);
        check_eq("miss_oe", 8'(d_oe), 8'd0);
        d_in = 4'h2; step();
        check_reset_outputs("unlk");
        fetch(8'hC3, CHIP, 1'b0, 8'h00);

        // Reset mid-drive in M1.
        sync_step();
        d_in = 4'hC; step();
        d_in = 4'h3; step();
        d_in = CHIP; step();
        check_eq("rstm1_pre_oe", 8'(d_oe), 8'd1);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("rstm1");
        step();
        rst_n = 1'b1;

        // Same-edge write during A3 read returns the old byte, then the new one.
        prog_we = 1'b1; prog_addr = 8'h3C; prog_data = 8'hA5;
        step();
        fetch(8'h3C, CHIP, 1'b1, 8'h11);
        fetch(8'h3C, CHIP, 1'b0, 8'h00);

        rand_prog = 1'b1;
        for (int n = 0; n < 80; n++) begin
            ra  = 8'($urandom);
            ra3 = ($urandom_range(0, 1) == 1) ? CHIP : 4'($urandom);
            fetch(ra, ra3, 1'b0, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
